vx_mat_tile_arb: RTL and testbench
==================================

# vx_mat_tile_arb

Tile-granular round-robin write arbiter for the shared matrix buffer. It grants one of NUM_REQS load streams exclusive write ownership until that stream has written one complete tile of narrow beats. Ownership is never handed over mid-tile, so packed register words are never interleaved between sources. It sits between the per-warp matrix load paths and the matrix buffer write port, and it honours the buffer's full flag.

## Interface
- NUM_REQS, 4: number of requesting load streams, ≥2.
- WIDTH, 32: matrix buffer register width in bits.
- NUM_REGS, 4: registers per buffer entry (one tile).
- INPUT_DATA_WIDTH, 8: beat width; WIDTH % INPUT_DATA_WIDTH must be 0.
- Derived BEATS = NUM_REGS*WIDTH/INPUT_DATA_WIDTH (16 at defaults).
- Reset and clock: i_rstn is asynchronous, active-low; i_clk is the clock.
- i_clk  in  1  clock
- i_rstn  in  1  async active-low reset
- i_req_valid  in  NUM_REQS  per-stream beat valid
- i_req_data  in  NUM_REQS×INPUT_DATA_WIDTH  per-stream beat data
- o_req_ready  out  NUM_REQS  per-stream beat accept
- o_buf_write  out  1  write strobe to matrix buffer
- o_buf_data  out  INPUT_DATA_WIDTH  beat to matrix buffer
- i_buf_full  in  1  matrix buffer full
- o_owner_valid  out  1  a tile transfer is in progress
- o_owner  out  $clog2(NUM_REQS)  current owner index
- o_tile_done  out  1  one-cycle pulse after a tile's last beat
- o_tile_src  out  $clog2(NUM_REQS)  source of the completed tile, valid with o_tile_done

## Operation
- FSM states:
  - IDLE: on any i_req_valid, pick the winner round-robin, searching from last_grant+1 upward with wrap. Load owner, set last_grant = winner, clear beat_cnt, go to LOCKED.
  - LOCKED: o_req_ready[owner] = !i_buf_full; all other readies are 0.
- A beat transfers when i_req_valid[owner] && o_req_ready[owner].
- o_buf_write equals that transfer condition, and o_buf_data = i_req_data[owner]. Both are combinational.
- beat_cnt is $clog2(BEATS) bits wide (minimum 1) and increments per transfer. The transfer with beat_cnt == BEATS-1 is the last beat. On the last beat: next state IDLE, o_tile_done registered high for exactly one cycle, o_tile_src = owner.
- Owner valid deasserted mid-tile: the arbiter holds ownership indefinitely. There is no timeout and no preemption.
- i_buf_full asserted mid-tile: the arbiter stalls without losing beat_cnt.
- Requests in IDLE with i_buf_full high: a grant is still issued; the first beat waits for !i_buf_full.
- Non-owner valids are ignored until the tile completes; their data must be held stable by the source.
- Reset values: state IDLE, owner 0, last_grant NUM_REQS-1 (requester 0 wins first), beat_cnt 0. All outputs are 0.
- Reset mid-tile abandons the partial tile; the buffer shares the same reset.

## Timing
- Grant latency: a request seen in IDLE at cycle t gives LOCKED with ready at t+1, so the first beat can transfer at t+1.
- Throughput: one beat per cycle while LOCKED, valid and !full.
- Last beat at cycle t gives o_tile_done at t+1, with state IDLE at t+1. The next grant decision is at t+1, and the next first beat is at t+2. There is one bubble per tile.
- o_owner_valid is high exactly in LOCKED.

## Configuration
- VX_MAT_ARB_PERF_EN defined: adds the following outputs.
  - o_perf_tiles[NUM_REQS][32]: counts completed tiles per requester.
  - o_perf_stall[32]: counts LOCKED cycles with i_buf_full high.
  - o_perf_wait[32]: counts cycles in which any non-owner valid is high while LOCKED.
  - All counters are reset to 0 and wrap modulo 2^32.
- VX_MAT_ARB_PERF_EN undefined: the ports and counters are absent. The functional behaviour is identical.

## Structure
- Package vx_mat_pkg holds:
  - the state enum (MAT_ARB_IDLE, MAT_ARB_LOCKED);
  - the beats-per-tile function of (NUM_REGS, WIDTH, INPUT_DATA_WIDTH), shared with the matrix buffer.
- Sub-module vx_rr_pick: a combinational round-robin picker taking a request vector and a last-grant index, returning a winner index and an any-valid flag. It is instantiated once.

## Test plan
- Single stream (defaults): req0 sends 16 beats 0x00..0x0F back-to-back, holding valid for 17 cycles → grant 1 cycle after valid; writes 0x00..0x0F on consecutive cycles; o_tile_done one cycle after 0x0F with o_tile_src=0.
- Contention: all 4 valid from reset → tiles complete in order 0,1,2,3,0. No beat from another source appears inside any 16-write run.
- Buffer full: assert i_buf_full for 5 cycles after beat 7 → no o_buf_write and ready low during those cycles; beat 8 issues the cycle full drops; the tile still totals 16 writes.
- Owner bubble: owner drops valid for 10 cycles mid-tile while req2 is valid → ownership is retained, o_req_ready[2]=0 throughout, and req2 is granted only after the owner's 16th beat.
- Reset mid-tile after beat 5 → all outputs 0 immediately. After release with req1 and req3 valid, req1 is granted first and beat_cnt restarts at 0.
- Perf counters (VX_MAT_ARB_PERF_EN): after the contention test and 5 full cycles, o_perf_tiles = {2,1,1,1} and o_perf_stall = 5.

Source files
------------

// File: rtl/vx_mat_pkg.sv
// Shared definitions for the matrix buffer write path.
//   mat_arb_state_e    : tile arbiter FSM states
//   mat_beats_per_tile : narrow beats needed to fill one buffer entry (tile),
//                        also used by the matrix buffer to size its packer
package vx_mat_pkg;

  typedef enum logic [0:0] {
    MAT_ARB_IDLE   = 1'b0,
    MAT_ARB_LOCKED = 1'b1
  } mat_arb_state_e;

  function automatic int unsigned mat_beats_per_tile(input int unsigned num_regs,
                                                     input int unsigned width,
                                                     input int unsigned in_width);
    return (num_regs * width) / in_width;
  endfunction

endpackage

// File: rtl/vx_mat_tile_arb_if.sv
// Bundle of the load-stream and matrix-buffer signals around the tile arbiter.
//   i_req_valid/i_req_data/o_req_ready : per-stream beat handshake
//   o_buf_write/o_buf_data/i_buf_full  : matrix buffer write port
//   o_owner_valid/o_owner              : current tile owner
//   o_tile_done/o_tile_src             : one-cycle tile completion pulse
// Handshake: a beat moves on a cycle where valid && ready are both high;
// valid may rise independently of ready, and a source must hold its data
// stable while valid is high and the beat has not been accepted.
// slave = arbiter side, master = stream/buffer (test) side.
interface vx_mat_tile_arb_if #(
  parameter int NUM_REQS         = 4,
  parameter int INPUT_DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]                       i_req_valid;
  logic [NUM_REQS-1:0][INPUT_DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQS-1:0]                       o_req_ready;
  logic                                      o_buf_write;
  logic [INPUT_DATA_WIDTH-1:0]               o_buf_data;
  logic                                      i_buf_full;
  logic                                      o_owner_valid;
  logic [IDX_W-1:0]                          o_owner;
  logic                                      o_tile_done;
  logic [IDX_W-1:0]                          o_tile_src;

  modport slave (
    input  i_req_valid, i_req_data, i_buf_full,
    output o_req_ready, o_buf_write, o_buf_data, o_owner_valid, o_owner,
           o_tile_done, o_tile_src
  );

  modport master (
    output i_req_valid, i_req_data, i_buf_full,
    input  o_req_ready, o_buf_write, o_buf_data, o_owner_valid, o_owner,
           o_tile_done, o_tile_src
  );
endinterface

// File: rtl/vx_rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector
//   i_last   : index granted last time; search starts at i_last+1 with wrap
//   o_winner : first requesting index found
//   o_any    : at least one request present
module vx_rr_pick #(
  parameter int NUM_REQS = 4
) (
  input  logic [NUM_REQS-1:0]         i_req,
  input  logic [$clog2(NUM_REQS)-1:0] i_last,
  output logic [$clog2(NUM_REQS)-1:0] o_winner,
  output logic                        o_any
);
  localparam int IDX_W = $clog2(NUM_REQS);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    o_winner = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      cand = IDX_W'((int'(i_last) + k) % NUM_REQS);
      if (!found && i_req[cand]) begin
        found    = 1'b1;
        o_winner = cand;
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/vx_mat_tile_arb.sv
// Tile-granular round-robin write arbiter for the shared matrix buffer.
// One load stream owns the buffer write port until it has written a full
// tile of BEATS narrow beats, so packed register words never interleave.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus           : vx_mat_tile_arb_if.slave (stream handshake, buffer port,
//                   owner and tile-done status)
//   o_dbg_state   : current FSM state
// Optional build macro VX_MAT_ARB_PERF_EN adds:
//   o_perf_tiles[NUM_REQS] : completed tiles per requester
//   o_perf_stall           : LOCKED cycles with buffer full
//   o_perf_wait            : LOCKED cycles with any non-owner valid
// WIDTH must be a multiple of INPUT_DATA_WIDTH.
module vx_mat_tile_arb
  import vx_mat_pkg::*;
#(
  parameter int NUM_REQS         = 4,
  parameter int WIDTH            = 32,
  parameter int NUM_REGS         = 4,
  parameter int INPUT_DATA_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  vx_mat_tile_arb_if.slave   bus,
  output mat_arb_state_e     o_dbg_state
`ifdef VX_MAT_ARB_PERF_EN
  ,
  output logic [31:0]        o_perf_tiles [NUM_REQS],
  output logic [31:0]        o_perf_stall,
  output logic [31:0]        o_perf_wait
`endif
);
  localparam int BEATS = int'(mat_beats_per_tile(NUM_REGS, WIDTH, INPUT_DATA_WIDTH));
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(NUM_REQS);

  mat_arb_state_e      state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                tile_done_q, tile_done_d;
  logic [IDX_W-1:0]    tile_src_q, tile_src_d;

  logic [NUM_REQS-1:0] req_ready;
  logic                xfer;
  logic                last_beat;
  logic [IDX_W-1:0]    winner;
  logic                any_valid;
  logic                locked;

  vx_rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
    .i_req    (bus.i_req_valid),
    .i_last   (last_grant_q),
    .o_winner (winner),
    .o_any    (any_valid)
  );

  assign locked = (state_q == MAT_ARB_LOCKED);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    tile_done_d  = 1'b0;
    tile_src_d   = '0;
    req_ready    = '0;
    xfer         = 1'b0;
    last_beat    = 1'b0;
    case (state_q)
      MAT_ARB_IDLE: begin
        // Grant is issued even when the buffer is full; the first beat
        // then simply waits in LOCKED.
        if (any_valid) begin
          owner_d      = winner;
          last_grant_d = winner;
          beat_cnt_d   = '0;
          state_d      = MAT_ARB_LOCKED;
        end
      end
      MAT_ARB_LOCKED: begin
        req_ready[owner_q] = !bus.i_buf_full;
        xfer               = bus.i_req_valid[owner_q] && !bus.i_buf_full;
        last_beat          = xfer && (beat_cnt_q == CNT_W'(BEATS - 1));
        if (last_beat) begin
          state_d     = MAT_ARB_IDLE;
          beat_cnt_d  = '0;
          tile_done_d = 1'b1;
          tile_src_d  = owner_q;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MAT_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= MAT_ARB_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQS - 1);
      beat_cnt_q   <= '0;
      tile_done_q  <= 1'b0;
      tile_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      tile_done_q  <= tile_done_d;
      tile_src_q   <= tile_src_d;
    end
  end

  assign bus.o_req_ready   = req_ready;
  assign bus.o_buf_write   = xfer;
  // Data is forced to zero outside LOCKED so every output reads 0 in reset.
  assign bus.o_buf_data    = locked ? bus.i_req_data[owner_q] : '0;
  assign bus.o_owner_valid = locked;
  assign bus.o_owner       = owner_q;
  assign bus.o_tile_done   = tile_done_q;
  assign bus.o_tile_src    = tile_src_q;
  assign o_dbg_state       = state_q;

`ifdef VX_MAT_ARB_PERF_EN
  logic [31:0]         perf_tiles_q [NUM_REQS];
  logic [31:0]         perf_tiles_d [NUM_REQS];
  logic [31:0]         perf_stall_q, perf_stall_d;
  logic [31:0]         perf_wait_q, perf_wait_d;
  logic [NUM_REQS-1:0] other_valid;

  always_comb begin
    perf_tiles_d = perf_tiles_q;
    if (last_beat) perf_tiles_d[owner_q] = perf_tiles_q[owner_q] + 32'd1;
    perf_stall_d = perf_stall_q + ((locked && bus.i_buf_full) ? 32'd1 : 32'd0);
    other_valid  = bus.i_req_valid & ~(NUM_REQS'(1) << owner_q);
    perf_wait_d  = perf_wait_q + ((locked && (|other_valid)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NUM_REQS; i++) perf_tiles_q[i] <= '0;
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_tiles_q <= perf_tiles_d;
      perf_stall_q <= perf_stall_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign o_perf_tiles = perf_tiles_q;
  assign o_perf_stall = perf_stall_q;
  assign o_perf_wait  = perf_wait_q;
`endif
endmodule

// File: tb/tb_vx_mat_tile_arb.sv
// Bench for vx_mat_tile_arb at default parameters (4 streams, 16 beats/tile).
// Stream i sends beats with data i*64 + n, so every written byte names its
// source and position. A per-cycle reference model checks all outputs.
module tb_vx_mat_tile_arb;
  import vx_mat_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int BEATS = 16;

  logic i_clk;
  logic i_rstn;
  mat_arb_state_e dbg_state;
`ifdef VX_MAT_ARB_PERF_EN
  logic [31:0] perf_tiles [NR];
  logic [31:0] perf_stall;
  logic [31:0] perf_wait;
`endif

  vx_mat_tile_arb_if #(.NUM_REQS(NR), .INPUT_DATA_WIDTH(DW)) bus ();

  vx_mat_tile_arb #(
    .NUM_REQS(NR), .WIDTH(32), .NUM_REGS(4), .INPUT_DATA_WIDTH(DW)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef VX_MAT_ARB_PERF_EN
    ,
    .o_perf_tiles (perf_tiles),
    .o_perf_stall (perf_stall),
    .o_perf_wait  (perf_wait)
`endif
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int left [NR];
  int cnt  [NR];
  bit hold [NR];
  bit acc  [NR];

  logic [DW-1:0] wr_data_log[$];
  int            wr_cyc_log[$];
  int            done_log[$];
  int            done_cyc_log[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_locked;
  int m_owner, m_last, m_beats, m_src;
  bit m_done;
  int m_tiles [NR];
  int m_stall, m_wait;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = NR - 1; m_beats = 0;
    m_done = 0; m_src = 0; m_stall = 0; m_wait = 0;
    for (int i = 0; i < NR; i++) m_tiles[i] = 0;
  endtask

  task automatic model_step();
    logic [NR-1:0] v;
    logic [NR-1:0] exp_ready;
    bit            exp_wr;
    bit            found;
    int            c;
    bit            full;
    v    = bus.i_req_valid;
    full = bus.i_buf_full;
    if (!i_rstn) model_reset();
    exp_ready = (m_locked && !full) ? NR'(1) << m_owner : '0;
    exp_wr    = m_locked && v[m_owner] && !full;
    chk("ready",       bus.o_req_ready, exp_ready);
    chk("write",       bus.o_buf_write, exp_wr);
    chk("data",        bus.o_buf_data, m_locked ? bus.i_req_data[m_owner] : '0);
    chk("owner_valid", bus.o_owner_valid, m_locked);
    chk("owner",       bus.o_owner, m_owner);
    chk("tile_done",   bus.o_tile_done, m_done);
    chk("tile_src",    bus.o_tile_src, m_done ? m_src : 0);
    chk("dbg_state",   dbg_state, m_locked ? MAT_ARB_LOCKED : MAT_ARB_IDLE);
`ifdef VX_MAT_ARB_PERF_EN
    for (int i = 0; i < NR; i++) chk("perf_tiles", perf_tiles[i], m_tiles[i]);
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_wait",  perf_wait, m_wait);
`endif
    if (!i_rstn) return;
    m_done = 0;
    m_src  = 0;
    if (m_locked) begin
      if (full) m_stall++;
      for (int i = 0; i < NR; i++)
        if (i != m_owner && v[i]) begin m_wait++; break; end
      if (exp_wr) begin
        m_beats++;
        if (m_beats == BEATS) begin
          m_locked = 0; m_done = 1; m_src = m_owner; m_beats = 0;
          m_tiles[m_owner]++;
        end
      end
    end else if (v != '0) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && v[c]) begin
          found = 1; m_owner = c; m_last = c;
        end
      end
      m_locked = 1;
      m_beats  = 0;
    end
  endtask

  // ---------------- monitor / compare (negedge) ----------------
  always @(negedge i_clk) begin
    cyc++;
    for (int i = 0; i < NR; i++) acc[i] = bus.i_req_valid[i] && bus.o_req_ready[i];
    if (bus.o_buf_write === 1'b1) begin
      wr_data_log.push_back(bus.o_buf_data);
      wr_cyc_log.push_back(cyc);
    end
    if (bus.o_tile_done === 1'b1) begin
      done_log.push_back(int'(bus.o_tile_src));
      done_cyc_log.push_back(cyc);
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    logic [NR-1:0]         v;
    logic [NR-1:0][DW-1:0] d;
    for (int i = 0; i < NR; i++) begin
      v[i] = (left[i] > 0) && !hold[i];
      d[i] = DW'(i * 64 + cnt[i]);
    end
    bus.i_req_valid = v;
    bus.i_req_data  = d;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i]) begin left[i]--; cnt[i]++; end
    drive();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin left[i] = 0; cnt[i] = 0; hold[i] = 0; end
    bus.i_buf_full = 1'b0;
    drive();
  endtask

  task automatic clear_logs();
    wr_data_log.delete(); wr_cyc_log.delete();
    done_log.delete(); done_cyc_log.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    clear_sources();
    cycle();
    cycle();
    i_rstn = 1'b1;
    clear_logs();
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int b = 0;
    while (wr_data_log.size() < n && b < budget) begin cycle(); b++; end
    chk(name, wr_data_log.size(), n);
  endtask

  task automatic wait_dones(input string name, input int n, input int budget);
    int b = 0;
    while (done_log.size() < n && b < budget) begin cycle(); b++; end
    chk(name, done_log.size(), n);
  endtask

  task automatic push_range(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(base + i));
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, wr_data_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_data_log.size(); i++)
      chk({name, "_beat"}, wr_data_log[i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  int start_cyc;

  initial begin
    i_rstn = 1'b0;
    clear_sources();
    model_reset();
    cycle();
    cycle();
    // reset values pinned directly
    chk("rst_owner_valid", bus.o_owner_valid, 1'b0);
    chk("rst_ready",       bus.o_req_ready, 4'b0000);
    chk("rst_write",       bus.o_buf_write, 1'b0);
    chk("rst_tile_done",   bus.o_tile_done, 1'b0);
    chk("rst_owner",       bus.o_owner, 2'd0);
    i_rstn = 1'b1;
    clear_logs();

    // 1: single stream, 16 back-to-back beats
    start_cyc = cyc;
    left[0] = 16;
    drive();
    wait_dones("t1_done_wait", 1, 60);
    push_range(0, 16);
    check_log("t1");
    if (wr_cyc_log.size() == 16 && done_cyc_log.size() == 1) begin
      chk("t1_grant_latency", wr_cyc_log[0], start_cyc + 2);
      chk("t1_back_to_back",  wr_cyc_log[15] - wr_cyc_log[0], 15);
      chk("t1_done_timing",   done_cyc_log[0], wr_cyc_log[15] + 1);
      chk("t1_done_src",      done_log[0], 0);
    end else chk("t1_log_shape", wr_cyc_log.size(), 16);

    // 2: contention from reset, 5 full cycles mid-run
    do_reset();
    left[0] = 32; left[1] = 16; left[2] = 16; left[3] = 16;
    drive();
    wait_writes("t2_mid_wait", 20, 100);
    bus.i_buf_full = 1'b1;
    repeat (5) cycle();
    bus.i_buf_full = 1'b0;
    wait_dones("t2_done_wait", 5, 200);
    push_range(0, 16); push_range(64, 16); push_range(128, 16);
    push_range(192, 16); push_range(16, 16);
    check_log("t2");
    for (int i = 0; i < 5 && i < done_log.size(); i++)
      chk("t2_done_order", done_log[i], (i == 4) ? 0 : i);
`ifdef VX_MAT_ARB_PERF_EN
    chk("t2_perf_tiles0", perf_tiles[0], 2);
    chk("t2_perf_tiles1", perf_tiles[1], 1);
    chk("t2_perf_tiles2", perf_tiles[2], 1);
    chk("t2_perf_tiles3", perf_tiles[3], 1);
    chk("t2_perf_stall",  perf_stall, 5);
`endif

    // 3: buffer full for 5 cycles after beat 7
    do_reset();
    left[0] = 16;
    drive();
    wait_writes("t3_mid_wait", 8, 40);
    bus.i_buf_full = 1'b1;
    repeat (5) cycle();
    bus.i_buf_full = 1'b0;
    wait_dones("t3_done_wait", 1, 60);
    push_range(0, 16);
    check_log("t3");
    if (wr_cyc_log.size() >= 9)
      chk("t3_stall_gap", wr_cyc_log[8] - wr_cyc_log[7], 6);

    // 4: owner drops valid for 10 cycles while req2 waits
    do_reset();
    left[0] = 16; left[2] = 16;
    drive();
    wait_writes("t4_mid_wait", 4, 40);
    hold[0] = 1;
    drive();
    repeat (10) cycle();
    hold[0] = 0;
    drive();
    wait_dones("t4_done_wait", 2, 100);
    push_range(0, 16); push_range(128, 16);
    check_log("t4");
    if (wr_cyc_log.size() >= 17 && done_cyc_log.size() >= 1) begin
      chk("t4_bubble_gap",  wr_cyc_log[4] - wr_cyc_log[3], 11);
      chk("t4_req2_start",  wr_cyc_log[16], done_cyc_log[0] + 1);
      chk("t4_done_src0",   done_log[0], 0);
    end

    // 5: reset after beat 5, then req1/req3 contend
    do_reset();
    left[0] = 16;
    drive();
    wait_writes("t5_mid_wait", 6, 40);
    i_rstn = 1'b0;
    clear_sources();
    #1;
    chk("t5_rst_owner_valid", bus.o_owner_valid, 1'b0);
    chk("t5_rst_ready",       bus.o_req_ready, 4'b0000);
    chk("t5_rst_write",       bus.o_buf_write, 1'b0);
    chk("t5_rst_data",        bus.o_buf_data, 8'h00);
    chk("t5_rst_tile_done",   bus.o_tile_done, 1'b0);
    chk("t5_rst_owner",       bus.o_owner, 2'd0);
    chk("t5_rst_tile_src",    bus.o_tile_src, 2'd0);
    cycle();
    cycle();
    i_rstn = 1'b1;
    clear_logs();
    left[1] = 16; left[3] = 16;
    drive();
    wait_dones("t5_done_wait", 2, 100);
    push_range(64, 16); push_range(192, 16);
    check_log("t5");
    if (done_log.size() == 2) begin
      chk("t5_first_src",  done_log[0], 1);
      chk("t5_second_src", done_log[1], 3);
    end

    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
